// File: rtl/vote_pkg.sv
// Shared definitions for the vote result announcer: default count width,
// candidate id constants and the announcer FSM state encoding.
package vote_pkg;

    localparam int unsigned CNT_W_DEF = 6;
    localparam int unsigned ID_W      = 2;

    localparam logic [ID_W-1:0] CAND_NONE = 2'd0;
    localparam logic [ID_W-1:0] CAND_1    = 2'd1;
    localparam logic [ID_W-1:0] CAND_2    = 2'd2;
    localparam logic [ID_W-1:0] CAND_3    = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/vote_max3.sv
// Combinational winner/tie decision over three unsigned candidate counts.
// A single candidate holding the maximum wins; a shared maximum (including
// all-zero counts) is a tie with no winner.
module vote_max3
    import vote_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic [CNT_W-1:0] count1,
    input  logic [CNT_W-1:0] count2,
    input  logic [CNT_W-1:0] count3,
    output logic [ID_W-1:0]  winner_c,
    output logic             tie_c
);

    logic [CNT_W-1:0] max_c;
    logic [2:0]       at_max_c;

    // Find the largest count and flag which candidates reach it.
    always_comb begin
        max_c = count1;
        if (count2 > max_c) max_c = count2;
        if (count3 > max_c) max_c = count3;
        at_max_c = {count3 == max_c, count2 == max_c, count1 == max_c};
    end

    // Exactly one candidate at the maximum wins; anything else is a tie.
    always_comb begin
        winner_c = CAND_NONE;
        tie_c    = 1'b0;
        case (at_max_c)
            3'b001:  winner_c = CAND_1;
            3'b010:  winner_c = CAND_2;
            3'b100:  winner_c = CAND_3;
            default: tie_c    = 1'b1;
        endcase
    end

endmodule

// File: rtl/vote_result_announcer.sv
// Freezes the three candidate counts on the rising edge of voting-over,
// registers the winner/tie decision, then streams one (id, count) record
// per candidate over a valid/ready handshake and latches done.
module vote_result_announcer
    import vote_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_voting_over,
    input  logic [CNT_W-1:0] i_count1,
    input  logic [CNT_W-1:0] i_count2,
    input  logic [CNT_W-1:0] i_count3,
    input  logic             i_rec_ready,
    output logic             o_rec_valid,
    output logic [ID_W-1:0]  o_rec_id,
    output logic [CNT_W-1:0] o_rec_count,
    output logic [ID_W-1:0]  o_winner,
    output logic             o_tie,
    output logic             o_done
);

    state_t           state_q, state_d;
    logic             vo_hist_q;
    logic [CNT_W-1:0] snap1_q, snap2_q, snap3_q;
    logic [CNT_W-1:0] snap1_d, snap2_d, snap3_d;
    logic             rec_valid_d;
    logic [ID_W-1:0]  rec_id_d;
    logic [CNT_W-1:0] rec_count_d;
    logic [ID_W-1:0]  winner_d;
    logic             tie_d;
    logic             done_d;
    logic [ID_W-1:0]  max_winner_c;
    logic             max_tie_c;
    logic             start_c;

    // Decision is taken on the frozen snapshots only.
    vote_max3 #(
        .CNT_W (CNT_W)
    ) u_max3 (
        .count1   (snap1_q),
        .count2   (snap2_q),
        .count3   (snap3_q),
        .winner_c (max_winner_c),
        .tie_c    (max_tie_c)
    );

    assign start_c = i_voting_over && !vo_hist_q;

    // State, snapshot and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vo_hist_q   <= 1'b0;
            snap1_q     <= '0;
            snap2_q     <= '0;
            snap3_q     <= '0;
            o_rec_valid <= 1'b0;
            o_rec_id    <= CAND_NONE;
            o_rec_count <= '0;
            o_winner    <= CAND_NONE;
            o_tie       <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vo_hist_q   <= i_voting_over;
            snap1_q     <= snap1_d;
            snap2_q     <= snap2_d;
            snap3_q     <= snap3_d;
            o_rec_valid <= rec_valid_d;
            o_rec_id    <= rec_id_d;
            o_rec_count <= rec_count_d;
            o_winner    <= winner_d;
            o_tie       <= tie_d;
            o_done      <= done_d;
        end
    end

    // Next-state and next-output logic; everything holds unless a state acts.
    always_comb begin
        state_d     = state_q;
        snap1_d     = snap1_q;
        snap2_d     = snap2_q;
        snap3_d     = snap3_q;
        rec_valid_d = o_rec_valid;
        rec_id_d    = o_rec_id;
        rec_count_d = o_rec_count;
        winner_d    = o_winner;
        tie_d       = o_tie;
        done_d      = o_done;

        case (state_q)
            IDLE: begin
                if (start_c) begin
                    snap1_d = i_count1;
                    snap2_d = i_count2;
                    snap3_d = i_count3;
                    state_d = CMP;
                end
            end
            CMP: begin
                winner_d    = max_winner_c;
                tie_d       = max_tie_c;
                rec_valid_d = 1'b1;
                rec_id_d    = CAND_1;
                rec_count_d = snap1_q;
                state_d     = SEND;
            end
            SEND: begin
                if (o_rec_valid && i_rec_ready) begin
                    case (o_rec_id)
                        CAND_1: begin
                            rec_id_d    = CAND_2;
                            rec_count_d = snap2_q;
                        end
                        CAND_2: begin
                            rec_id_d    = CAND_3;
                            rec_count_d = snap3_q;
                        end
                        default: begin
                            // Last record accepted: stream complete.
                            rec_valid_d = 1'b0;
                            done_d      = 1'b1;
                            state_d     = DONE;
                        end
                    endcase
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vote_result_announcer.sv
// Randomized and directed bench for vote_result_announcer with a
// behavioural winner/tie model and an expected record list.
module tb_vote_result_announcer;

    localparam int unsigned CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_voting_over;
    logic [CNT_W-1:0] i_count1, i_count2, i_count3;
    logic             i_rec_ready;
    logic             o_rec_valid;
    logic [1:0]       o_rec_id;
    logic [CNT_W-1:0] o_rec_count;
    logic [1:0]       o_winner;
    logic             o_tie;
    logic             o_done;

    int n_cmp = 0;
    int n_bad = 0;

    vote_result_announcer #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_voting_over (i_voting_over),
        .i_count1      (i_count1),
        .i_count2      (i_count2),
        .i_count3      (i_count3),
        .i_rec_ready   (i_rec_ready),
        .o_rec_valid   (o_rec_valid),
        .o_rec_id      (o_rec_id),
        .o_rec_count   (o_rec_count),
        .o_winner      (o_winner),
        .o_tie         (o_tie),
        .o_done        (o_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"},  32'(o_rec_valid), 0);
        check({tag, "_id"},     32'(o_rec_id), 0);
        check({tag, "_count"},  32'(o_rec_count), 0);
        check({tag, "_winner"}, 32'(o_winner), 0);
        check({tag, "_tie"},    32'(o_tie), 0);
        check({tag, "_done"},   32'(o_done), 0);
    endtask

    // Assert reset between clock edges and confirm outputs clear without a clock.
    task automatic do_reset(input logic vo_level);
        @(negedge clk);
        #1;
        rst           = 1'b1;
        i_voting_over = vo_level;
        i_rec_ready   = 1'b0;
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference: winner is the unique holder of the maximum, otherwise a tie.
    task automatic model(input int unsigned c[3], output int unsigned w, output int unsigned t);
        int unsigned mx;
        int unsigned n;
        mx = c[0];
        for (int i = 1; i < 3; i++) if (c[i] > mx) mx = c[i];
        n = 0;
        w = 0;
        for (int i = 0; i < 3; i++) begin
            if (c[i] == mx) begin
                n++;
                w = i + 1;
            end
        end
        t = (n > 1) ? 1 : 0;
        if (n > 1) w = 0;
    endtask

    function automatic logic pick_ready(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return 1'($urandom_range(0, 1));
            default: return (cyc < 5) ? 1'b0 : ((cyc - 5) % 2 == 0);
        endcase
    endfunction

    // Run one announcement from a negedge: capture c*, switch inputs to a*
    // after capture, stream records under the chosen ready pattern.
    // abort_idx >= 0 asserts reset while that record index is pending.
    task automatic announce(input int unsigned c1, c2, c3,
                            input int unsigned a1, a2, a3,
                            input int mode, input int abort_idx);
        int unsigned snap[3];
        int unsigned ew, et;
        int idx, cyc;
        logic rdy;
        snap = '{c1, c2, c3};
        model(snap, ew, et);
        i_count1      = CNT_W'(c1);
        i_count2      = CNT_W'(c2);
        i_count3      = CNT_W'(c3);
        i_voting_over = 1'b1;
        i_rec_ready   = 1'b0;
        @(posedge clk); @(negedge clk);
        check("valid_after_e0", 32'(o_rec_valid), 0);
        i_count1 = CNT_W'(a1);
        i_count2 = CNT_W'(a2);
        i_count3 = CNT_W'(a3);
        @(posedge clk); @(negedge clk);
        check("winner", 32'(o_winner), ew);
        check("tie", 32'(o_tie), et);
        idx = 0;
        cyc = 0;
        while (idx < 3 && cyc < 200) begin
            check("rec_valid", 32'(o_rec_valid), 1);
            check("rec_id", 32'(o_rec_id), idx + 1);
            check("rec_count", 32'(o_rec_count), snap[idx]);
            check("done_early", 32'(o_done), 0);
            check("winner_hold", 32'(o_winner), ew);
            if (idx == abort_idx) begin
                #2;
                rst = 1'b1;
                #1;
                check_zero("abort");
                return;
            end
            rdy = pick_ready(mode, cyc);
            i_rec_ready = rdy;
            i_voting_over = 1'($urandom_range(0, 1));
            @(posedge clk); @(negedge clk);
            if (rdy) idx++;
            cyc++;
        end
        check("stream_timeout", 32'(idx), 3);
        check("end_valid", 32'(o_rec_valid), 0);
        check("end_done", 32'(o_done), 1);
        check("end_winner", 32'(o_winner), ew);
        check("end_tie", 32'(o_tie), et);
        i_rec_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_voting_over = ~i_voting_over;
            @(posedge clk); @(negedge clk);
            check("done_valid", 32'(o_rec_valid), 0);
            check("done_hold", 32'(o_done), 1);
            check("done_id", 32'(o_rec_id), 3);
            check("done_count", 32'(o_rec_count), snap[2]);
        end
    endtask

    initial begin
        int unsigned r[3];
        int m;
        rst           = 1'b1;
        i_voting_over = 1'b0;
        i_count1      = '0;
        i_count2      = '0;
        i_count3      = '0;
        i_rec_ready   = 1'b0;

        // Input already high at reset release counts as a rising edge.
        do_reset(1'b1);
        announce(4, 6, 2, 4, 6, 2, 0, -1);
        do_reset(1'b0);
        announce(5, 5, 1, 5, 5, 1, 0, -1);
        do_reset(1'b0);
        announce(0, 0, 0, 0, 0, 0, 0, -1);
        do_reset(1'b0);
        announce(3, 1, 7, 3, 1, 7, 2, -1);
        do_reset(1'b0);
        announce(2, 2, 3, 9, 9, 9, 0, -1);
        do_reset(1'b0);
        announce(5, 2, 6, 5, 2, 6, 0, 1);
        do_reset(1'b0);
        announce(1, 0, 0, 1, 0, 0, 0, -1);
        do_reset(1'b0);
        announce(63, 62, 63, 63, 62, 63, 1, -1);

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 3; i++)
                r[i] = (n % 2 == 0) ? $urandom_range(0, 2) : $urandom_range(0, 63);
            m = int'($urandom_range(0, 2));
            do_reset(1'b0);
            announce(r[0], r[1], r[2], $urandom_range(0, 63), $urandom_range(0, 63),
                     $urandom_range(0, 63), m, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
